// File: rtl/mtimer_pkg.sv
// Shared constants and helpers for the machine-timer bank: register word offsets,
// CTRL field positions and the byte-lane merge used by every writable register.
package mtimer_pkg;

  localparam logic [29:0] OFFSET_MTIME_LO = 30'd0;
  localparam logic [29:0] OFFSET_MTIME_HI = 30'd1;
  localparam logic [29:0] OFFSET_CTRL     = 30'd2;
  localparam logic [29:0] OFFSET_STATUS   = 30'd3;
  localparam logic [29:0] OFFSET_CMP_BASE = 30'd4;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_DIVISOR_LSB = 8;

  // Word offset of CMP_i_LO; CMP_i_HI sits one word above it.
  function automatic logic [29:0] cmp_offset(input int unsigned i);
    return OFFSET_CMP_BASE + 30'(2 * i);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sections);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sections[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mtimer_bank_if.sv
// Core data-bus port of the timer bank: one access per cycle, read data returns
// registered on the following cycle.
interface mtimer_bank_if;
  // Access protocol: the address is held for the access cycle; any non-zero
  // memory_write_sections makes it a write, zero makes it a read (or idle).
  // read_value/read_hit describe the previous cycle's address and need no handshake.
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic [3:0]  memory_write_sections;
  logic [31:0] read_value;
  logic        read_hit;

  modport master (
    output memory_address, memory_write_value, memory_write_sections,
    input  read_value, read_hit
  );

  modport slave (
    input  memory_address, memory_write_value, memory_write_sections,
    output read_value, read_hit
  );
endinterface

// File: rtl/mtimer_comparator.sv
// One 64-bit byte-writable compare register (reset all-ones) with a registered
// unsigned mtime >= compare flag.
module mtimer_comparator
  import mtimer_pkg::*;
(
  input  logic        clk24,
  input  logic        reset,
  input  logic [3:0]  lo_sections,
  input  logic [3:0]  hi_sections,
  input  logic [31:0] write_value,
  input  logic [63:0] mtime,
  output logic [63:0] compare_value,
  output logic        pending
);

  always_ff @(posedge clk24) begin
    if (reset) begin
      compare_value <= '1;
      pending       <= 1'b0;
    end else begin
      compare_value <= {merge_bytes(compare_value[63:32], write_value, hi_sections),
                        merge_bytes(compare_value[31:0],  write_value, lo_sections)};
      // Compares the values held this cycle, so a new CMP takes effect one cycle later.
      pending       <= (mtime >= compare_value);
    end
  end

endmodule

// File: rtl/mtimer_bank.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, tear-free high-word
// snapshot, and NUM_COMPARATORS compare registers each driving a pending line.
module mtimer_bank
  import mtimer_pkg::*;
#(
  parameter int          NUM_COMPARATORS = 2,
  parameter logic [31:0] BASE_ADDRESS    = 32'h8000_0000,
  parameter int          PRESCALE_WIDTH  = 8
) (
  input  logic                       clk24,
  input  logic                       reset,
  mtimer_bank_if.slave               bus,
  output logic [NUM_COMPARATORS-1:0] interrupt_pending,
  output logic                       mip_mtip
);

  localparam logic [29:0] NUM_WORDS = 30'(OFFSET_CMP_BASE + 30'(2 * NUM_COMPARATORS));

  logic [29:0] offset;
  logic        hit;
  logic        write_any;
  logic        wr_lo, wr_hi, wr_ctrl, rd_lo, rd_hi;

  // Addresses below the base wrap to huge offsets and fall out of range.
  assign offset    = bus.memory_address[31:2] - BASE_ADDRESS[31:2];
  assign hit       = (offset < NUM_WORDS);
  assign write_any = |bus.memory_write_sections;
  assign wr_lo     = hit && write_any  && (offset == OFFSET_MTIME_LO);
  assign wr_hi     = hit && write_any  && (offset == OFFSET_MTIME_HI);
  assign wr_ctrl   = hit && write_any  && (offset == OFFSET_CTRL);
  assign rd_lo     = hit && !write_any && (offset == OFFSET_MTIME_LO);
  assign rd_hi     = hit && !write_any && (offset == OFFSET_MTIME_HI);

  logic [63:0]               mtime;
  logic [PRESCALE_WIDTH-1:0] prescale_count;
  logic [PRESCALE_WIDTH-1:0] divisor;
  logic                      enable;
  logic [31:0]               snapshot;
  logic                      snapshot_valid;
  logic [31:0]               ctrl_word;
  logic [31:0]               ctrl_written;
  logic                      tick;

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_ENABLE_BIT] = enable;
    ctrl_word[CTRL_DIVISOR_LSB +: PRESCALE_WIDTH] = divisor;
  end

  assign ctrl_written = merge_bytes(ctrl_word, bus.memory_write_value, bus.memory_write_sections);
  assign tick         = enable && (prescale_count == divisor);

  always_ff @(posedge clk24) begin
    if (reset) begin
      mtime          <= '0;
      prescale_count <= '0;
      enable         <= 1'b1;
      divisor        <= '0;
      snapshot       <= '0;
      snapshot_valid <= 1'b0;
    end else begin
      // A software write to either half wins over the increment in that cycle.
      if (wr_lo) begin
        mtime[31:0] <= merge_bytes(mtime[31:0], bus.memory_write_value, bus.memory_write_sections);
      end else if (wr_hi) begin
        mtime[63:32] <= merge_bytes(mtime[63:32], bus.memory_write_value, bus.memory_write_sections);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr_ctrl) begin
        prescale_count <= '0;
        enable         <= ctrl_written[CTRL_ENABLE_BIT];
        divisor        <= ctrl_written[CTRL_DIVISOR_LSB +: PRESCALE_WIDTH];
      end else if (enable) begin
        prescale_count <= tick ? '0 : prescale_count + PRESCALE_WIDTH'(1);
      end

      if (wr_lo || wr_hi || rd_hi) begin
        snapshot_valid <= 1'b0;
      end else if (rd_lo) begin
        snapshot       <= mtime[63:32];
        snapshot_valid <= 1'b1;
      end
    end
  end

  logic [63:0] compare_value [NUM_COMPARATORS];

  for (genvar i = 0; i < NUM_COMPARATORS; i++) begin : g_cmp
    logic [3:0] lo_sections;
    logic [3:0] hi_sections;

    assign lo_sections = (hit && offset == cmp_offset(i))
                         ? bus.memory_write_sections : 4'b0000;
    assign hi_sections = (hit && offset == cmp_offset(i) + 30'd1)
                         ? bus.memory_write_sections : 4'b0000;

    mtimer_comparator u_cmp (
      .clk24         (clk24),
      .reset         (reset),
      .lo_sections   (lo_sections),
      .hi_sections   (hi_sections),
      .write_value   (bus.memory_write_value),
      .mtime         (mtime),
      .compare_value (compare_value[i]),
      .pending       (interrupt_pending[i])
    );
  end

  logic [31:0] read_next;

  // Read data comes from pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    read_next = '0;
    if (hit) begin
      if (offset == OFFSET_MTIME_LO) begin
        read_next = mtime[31:0];
      end else if (offset == OFFSET_MTIME_HI) begin
        read_next = snapshot_valid ? snapshot : mtime[63:32];
      end else if (offset == OFFSET_CTRL) begin
        read_next = ctrl_word;
      end else if (offset == OFFSET_STATUS) begin
        read_next[NUM_COMPARATORS-1:0] = interrupt_pending;
      end else begin
        for (int i = 0; i < NUM_COMPARATORS; i++) begin
          if (offset == cmp_offset(i))         read_next = compare_value[i][31:0];
          if (offset == cmp_offset(i) + 30'd1) read_next = compare_value[i][63:32];
        end
      end
    end
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      bus.read_value <= '0;
      bus.read_hit   <= 1'b0;
    end else begin
      bus.read_value <= read_next;
      bus.read_hit   <= hit;
    end
  end

  assign mip_mtip = |interrupt_pending;

  logic unused_bits;
  assign unused_bits = ^{bus.memory_address[1:0], ctrl_written};

endmodule

// File: tb/tb_mtimer_bank.sv
// Directed bench for mtimer_bank: counting, prescaler, snapshot/wrap, byte writes,
// compare interrupts and mid-operation reset, with hand-computed expectations.
module tb_mtimer_bank;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam logic [31:0] A_LO      = BASE + 32'h00;
  localparam logic [31:0] A_HI      = BASE + 32'h04;
  localparam logic [31:0] A_CTRL    = BASE + 32'h08;
  localparam logic [31:0] A_STATUS  = BASE + 32'h0C;
  localparam logic [31:0] A_CMP0_LO = BASE + 32'h10;
  localparam logic [31:0] A_CMP0_HI = BASE + 32'h14;
  localparam logic [31:0] A_CMP1_LO = BASE + 32'h18;
  localparam logic [31:0] A_CMP1_HI = BASE + 32'h1C;

  logic       clk24 = 1'b0;
  logic       reset;
  logic [1:0] interrupt_pending;
  logic       mip_mtip;

  mtimer_bank_if bus_if ();

  mtimer_bank #(
    .NUM_COMPARATORS (2),
    .BASE_ADDRESS    (BASE),
    .PRESCALE_WIDTH  (8)
  ) dut (
    .clk24             (clk24),
    .reset             (reset),
    .bus               (bus_if),
    .interrupt_pending (interrupt_pending),
    .mip_mtip          (mip_mtip)
  );

  always #5 clk24 = ~clk24;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk24);
  endtask

  task automatic bus_idle();
    bus_if.memory_address        = 32'h0;
    bus_if.memory_write_value    = 32'h0;
    bus_if.memory_write_sections = 4'b0000;
  endtask

  // Drives one write cycle; last_rd holds the read data registered in that cycle.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    bus_if.memory_address        = addr;
    bus_if.memory_write_value    = data;
    bus_if.memory_write_sections = strb;
    @(negedge clk24);
    last_rd = bus_if.read_value;
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] addr);
    bus_if.memory_address        = addr;
    bus_if.memory_write_value    = 32'h0;
    bus_if.memory_write_sections = 4'b0000;
    @(negedge clk24);
    rd_data = bus_if.read_value;
    rd_hit  = bus_if.read_hit;
    bus_idle();
  endtask

  // Comments P<k> name the k-th rising edge after reset release.
  initial begin
    reset = 1'b1;
    bus_idle();
    idle(3);
    check("reset_read_value", bus_if.read_value, 32'h0);
    check("reset_read_hit", bus_if.read_hit, 1'b0);
    check("reset_pending", interrupt_pending, 2'b00);
    check("reset_mip", mip_mtip, 1'b0);
    reset = 1'b0;

    // Counting with divisor 0: mtime == k after Pk.
    idle(10);
    bus_read(A_LO);                        // P11
    check("count_lo", rd_data, 32'd10);
    check("count_hit", rd_hit, 1'b1);
    idle(1);                               // P12, idle address
    check("idle_hit_low", bus_if.read_hit, 1'b0);
    check("idle_value_zero", bus_if.read_value, 32'h0);
    bus_read(A_HI);                        // P13
    check("count_hi", rd_data, 32'h0);
    bus_read(A_CTRL);                      // P14
    check("ctrl_reset", rd_data, 32'h1);
    bus_read(A_STATUS);                    // P15
    check("status_reset", rd_data, 32'h0);
    bus_read(BASE + 32'h20);               // P16, first unmapped word
    check("oor_hit", rd_hit, 1'b0);
    check("oor_value", rd_data, 32'h0);
    bus_read(BASE + 32'h09);               // P17, low address bits ignored
    check("ctrl_unaligned", rd_data, 32'h1);
    bus_read(32'h7FFF_FFFC);               // P18, below base
    check("below_base_hit", rd_hit, 1'b0);
    bus_read(BASE + 32'h02);               // P19
    check("lo_unaligned", rd_data, 32'd18);

    // Prescaler: divisor 3 started from mtime 0 with count 0 (enable was off).
    bus_write(A_CTRL, 32'h0, 4'b1111);     // P20
    bus_write(A_LO, 32'h0, 4'b1111);       // P21
    bus_write(A_CTRL, 32'h0000_0301, 4'b1111); // P22; ticks at P26, P30, P34, P38
    idle(4);
    bus_read(A_LO);                        // P27
    check("prescale_first", rd_data, 32'd1);
    idle(2);
    bus_read(A_LO);                        // P30, sees value before that tick
    check("prescale_hold", rd_data, 32'd1);
    bus_read(A_LO);                        // P31
    check("prescale_second", rd_data, 32'd2);
    idle(7);
    bus_read(A_LO);                        // P39
    check("prescale_fourth", rd_data, 32'd4);
    bus_read(A_CTRL);                      // P40
    check("ctrl_readback", rd_data, 32'h0000_0301);
    bus_write(A_CTRL, 32'hFFFF_FE00, 4'b1111); // P41: disable, divisor 0xFE
    idle(20);
    bus_read(A_LO);                        // P62
    check("frozen_lo", rd_data, 32'd4);
    bus_read(A_CTRL);                      // P63
    check("ctrl_masked", rd_data, 32'h0000_FE00);

    // Wrap of the low word and the high-word snapshot.
    bus_write(A_LO, 32'hFFFF_FFFF, 4'b1111); // P64
    bus_write(A_HI, 32'h0, 4'b1111);       // P65
    bus_write(A_CTRL, 32'h1, 4'b1111);     // P66
    bus_read(A_LO);                        // P67
    check("wrap_lo", rd_data, 32'hFFFF_FFFF);
    bus_read(A_HI);                        // P68
    check("snapshot_hi", rd_data, 32'h0);
    bus_read(A_HI);                        // P69
    check("live_hi", rd_data, 32'h1);

    // Byte-lane writes; mtime after Pk is 0x1_0000_0000 + (k - 67) here.
    bus_write(A_CMP1_LO, 32'h0000_AB00, 4'b0010); // P70
    check("write_read_prewrite", last_rd, 32'hFFFF_FFFF);
    bus_read(A_CMP1_LO);                   // P71
    check("cmp1_lo_byte", rd_data, 32'hFFFF_ABFF);
    bus_read(A_CMP1_HI);                   // P72
    check("cmp1_hi_kept", rd_data, 32'hFFFF_FFFF);
    bus_read(A_LO);                        // P73
    check("cmp_write_no_suppress", rd_data, 32'd5);
    bus_write(A_HI, 32'h0, 4'b0001);       // P74, low word held at 6
    bus_read(A_LO);                        // P75
    check("mtime_write_suppress", rd_data, 32'd6);
    bus_read(A_HI);                        // P76
    check("hi_byte_write", rd_data, 32'h0);

    // Interrupts: CMP_0 = 0x20, mtime restarts from 0 after P82.
    bus_write(A_CTRL, 32'h0, 4'b1111);     // P77
    bus_write(A_CMP0_HI, 32'h0, 4'b1111);  // P78
    bus_write(A_CMP0_LO, 32'h20, 4'b1111); // P79
    bus_write(A_LO, 32'h0, 4'b1111);       // P80
    bus_write(A_HI, 32'h0, 4'b1111);       // P81
    bus_write(A_CTRL, 32'h1, 4'b1111);     // P82
    idle(32);                              // P114: mtime reaches 0x20
    check("pending_before", interrupt_pending, 2'b00);
    idle(1);                               // P115
    check("pending_rise", interrupt_pending, 2'b01);
    check("mip_rise", mip_mtip, 1'b1);
    bus_read(A_STATUS);                    // P116
    check("status_pending", rd_data, 32'h1);
    bus_write(A_CMP0_LO, 32'h0000_1000, 4'b1111); // P117
    check("cmp0_prewrite", last_rd, 32'h20);
    check("pending_still", interrupt_pending, 2'b01);
    idle(1);                               // P118
    check("pending_fall", interrupt_pending, 2'b00);
    check("mip_fall", mip_mtip, 1'b0);

    // Reset during a CMP write while pending.
    bus_write(A_CMP0_LO, 32'h0, 4'b1111);  // P119
    idle(1);                               // P120
    check("pending_pre_reset", interrupt_pending, 2'b01);
    reset = 1'b1;
    bus_write(A_CMP1_LO, 32'h0, 4'b1111);  // P121 with reset
    reset = 1'b0;
    check("midreset_pending", interrupt_pending, 2'b00);
    check("midreset_mip", mip_mtip, 1'b0);
    check("midreset_read_hit", bus_if.read_hit, 1'b0);
    bus_read(A_CMP1_LO);                   // P122
    check("midreset_cmp1_discard", rd_data, 32'hFFFF_FFFF);
    bus_read(A_CMP0_LO);                   // P123
    check("midreset_cmp0", rd_data, 32'hFFFF_FFFF);
    bus_read(A_LO);                        // P124
    check("midreset_mtime", rd_data, 32'd2);
    bus_read(A_CTRL);                      // P125
    check("midreset_ctrl", rd_data, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
